alu_share_arb: RTL and testbench

- Sequencer and arbiter that shares one combinational 8-bit ALU between two requesters, for example the integer execute path and a debug/test port.
- Each requester issues an operation through a valid/ready handshake. The block grants the ALU round-robin, latches operands, drives the ALU, captures its result and returns it on a per-requester response handshake.
- The ALU instance is external. This block only drives the ALU inputs and samples its output.

---
 rtl/alu_share_arb_if.sv | 48 ++++
 rtl/alu_share_arb.sv | 124 ++++++++++++
 tb/tb_alu_share_arb.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arb_if.sv
// Handshake and ALU bus bundle for alu_share_arb: two request/response
// channels plus the registered operand path to an external ALU.
interface alu_share_arb_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic [OPW-1:0]   req0_aluop;
    logic             resp0_valid;
    logic             resp0_ready;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
    logic [OPW-1:0]   req1_aluop;
    logic             resp1_valid;
    logic             resp1_ready;

    logic [WIDTH-1:0] resp_y;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_cin;
    logic [OPW-1:0]   alu_aluop;
    logic [WIDTH-1:0] alu_y;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin, req0_aluop, resp0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin, req1_aluop, resp1_ready,
        input  alu_y,
        output req0_ready, resp0_valid, req1_ready, resp1_valid,
        output resp_y, alu_a, alu_b, alu_cin, alu_aluop, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin, req0_aluop, resp0_ready,
        output req1_valid, req1_a, req1_b, req1_cin, req1_aluop, resp1_ready,
        output alu_y,
        input  req0_ready, resp0_valid, req1_ready, resp1_valid,
        input  resp_y, alu_a, alu_b, alu_cin, alu_aluop, busy
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin sequencer sharing one external combinational ALU between two
// requesters. Optional grant/conflict counters: ALU_SHARE_ARB_PERF_EN.
module alu_share_arb #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
`ifdef ALU_SHARE_ARB_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic           clk,
    input  logic           rst,
    alu_share_arb_if.slave bus
`ifdef ALU_SHARE_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;   // 1: requester 1 owns the ALU
    logic             prio_q, prio_d;     // requester that wins the next tie
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
    logic             cin_q, cin_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             gnt0, gnt1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        op_d    = op_q;
        y_d     = y_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
                gnt1 = bus.req1_valid && (!bus.req0_valid || prio_q);
                if (gnt0 || gnt1) begin
                    state_d = EXEC;
                    owner_d = gnt1;
                    prio_d  = gnt0;
                    a_d     = gnt1 ? bus.req1_a     : bus.req0_a;
                    b_d     = gnt1 ? bus.req1_b     : bus.req0_b;
                    cin_d   = gnt1 ? bus.req1_cin   : bus.req0_cin;
                    op_d    = gnt1 ? bus.req1_aluop : bus.req0_aluop;
                end
            end
            EXEC: begin
                y_d     = bus.alu_y;
                state_d = RESP;
            end
            RESP: begin
                if (owner_q ? bus.resp1_ready : bus.resp0_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            op_q    <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            op_q    <= op_d;
            y_q     <= y_d;
        end
    end

    // Grants are combinational from valid, so they are masked while rst holds.
    assign bus.req0_ready  = gnt0 && !rst;
    assign bus.req1_ready  = gnt1 && !rst;
    assign bus.resp0_valid = (state_q == RESP) && !owner_q;
    assign bus.resp1_valid = (state_q == RESP) && owner_q;
    assign bus.resp_y      = y_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_cin     = cin_q;
    assign bus.alu_aluop   = op_q;
    assign bus.busy        = (state_q != IDLE);

`ifdef ALU_SHARE_ARB_PERF_EN
    logic [CNT_W-1:0] g0_cnt_q, g1_cnt_q, cf_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g0_cnt_q <= '0;
            g1_cnt_q <= '0;
            cf_cnt_q <= '0;
        end else begin
            if (gnt0 && g0_cnt_q != '1)
                g0_cnt_q <= g0_cnt_q + CNT_W'(1);
            if (gnt1 && g1_cnt_q != '1)
                g1_cnt_q <= g1_cnt_q + CNT_W'(1);
            if (state_q == IDLE && bus.req0_valid && bus.req1_valid && cf_cnt_q != '1)
                cf_cnt_q <= cf_cnt_q + CNT_W'(1);
        end
    end

    assign grant0_cnt   = g0_cnt_q;
    assign grant1_cnt   = g1_cnt_q;
    assign conflict_cnt = cf_cnt_q;
`endif
endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: expected results are queued at each
// accepted request and popped when the owning response channel fires.
module tb_alu_share_arb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       owner;
        logic [7:0] y;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   grant_cyc[$];
    int   cyc = 0;
    int   nchk = 0;
    int   nfail = 0;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic cin, input logic [3:0] op);
        case (op)
            4'd7:    return a + b + {7'd0, cin};
            4'd1:    return a & b;
            4'd2:    return a ^ b;
            default: return a - b;
        endcase
    endfunction

    alu_share_arb_if #(.WIDTH(8), .OPW(4)) bus ();
    assign bus.alu_y = alu_model(bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_aluop);

`ifdef ALU_SHARE_ARB_PERF_EN
    logic [15:0] g0_cnt, g1_cnt, cf_cnt;
    logic [1:0]  g0_s, g1_s, cf_s;

    alu_share_arb #(.WIDTH(8), .OPW(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .grant0_cnt(g0_cnt), .grant1_cnt(g1_cnt), .conflict_cnt(cf_cnt)
    );

    // Narrow-counter copy fed from the same request stimulus.
    alu_share_arb_if #(.WIDTH(8), .OPW(4)) bus2 ();
    assign bus2.req0_valid  = bus.req0_valid;
    assign bus2.req0_a      = bus.req0_a;
    assign bus2.req0_b      = bus.req0_b;
    assign bus2.req0_cin    = bus.req0_cin;
    assign bus2.req0_aluop  = bus.req0_aluop;
    assign bus2.resp0_ready = bus.resp0_ready;
    assign bus2.req1_valid  = bus.req1_valid;
    assign bus2.req1_a      = bus.req1_a;
    assign bus2.req1_b      = bus.req1_b;
    assign bus2.req1_cin    = bus.req1_cin;
    assign bus2.req1_aluop  = bus.req1_aluop;
    assign bus2.resp1_ready = bus.resp1_ready;
    assign bus2.alu_y = alu_model(bus2.alu_a, bus2.alu_b, bus2.alu_cin, bus2.alu_aluop);

    alu_share_arb #(.WIDTH(8), .OPW(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .grant0_cnt(g0_s), .grant1_cnt(g1_s), .conflict_cnt(cf_s)
    );
`else
    alu_share_arb #(.WIDTH(8), .OPW(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req0_valid && bus.req0_ready) begin
                exp_q.push_back('{1'b0, alu_model(bus.req0_a, bus.req0_b, bus.req0_cin, bus.req0_aluop)});
                grant_log.push_back(0);
                grant_cyc.push_back(cyc);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                exp_q.push_back('{1'b1, alu_model(bus.req1_a, bus.req1_b, bus.req1_cin, bus.req1_aluop)});
                grant_log.push_back(1);
                grant_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic set0(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic [3:0] op);
        bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_aluop = op;
    endtask

    task automatic set1(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic [3:0] op);
        bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_aluop = op;
    endtask

    function automatic logic [33:0] all_outs();
        return {bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.resp_y,
                bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_aluop, bus.busy};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        samp();
        nchk++;
        if (all_outs() !== 34'd0) begin
            nfail++; $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
`ifdef ALU_SHARE_ARB_PERF_EN
        nchk++;
        if ({g0_cnt, g1_cnt, cf_cnt} !== 48'd0) begin
            nfail++; $display("FAIL reset_counters: got %h want 0", {g0_cnt, g1_cnt, cf_cnt});
        end
`endif
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst = 1'b0;
        samp();
        nchk++;
        if (bus.busy !== 1'b0) begin
            nfail++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_single_op();
        exp_t e;
        logic r1seen = 1'b0;
        tick();
        set0(8'h93, 8'hA7, 1'b1, 4'd7);
        bus.req0_valid = 1'b1; bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b0;
        samp();
        r1seen |= bus.resp1_valid;
        nchk++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            nfail++; $display("FAIL single_accept: ready0/1=%b want 10", {bus.req0_ready, bus.req1_ready});
        end
        tick();
        bus.req0_valid = 1'b0;
        samp();
        r1seen |= bus.resp1_valid;
        nchk++;
        if ({bus.resp0_valid, bus.busy} !== 2'b01) begin
            nfail++; $display("FAIL single_exec: resp0_valid,busy=%b want 01", {bus.resp0_valid, bus.busy});
        end
        tick();
        samp();
        r1seen |= bus.resp1_valid;
        nchk++;
        if (bus.resp0_valid !== 1'b1) begin
            nfail++; $display("FAIL single_resp_valid: got %b want 1", bus.resp0_valid);
        end
        nchk++;
        if (exp_q.size() != 1) begin
            nfail++; $display("FAIL single_sb_depth: got %0d want 1", exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (bus.resp_y !== e.y || e.y !== 8'h3B) begin
                nfail++; $display("FAIL single_y: got %h want %h", bus.resp_y, e.y);
            end
        end
        tick();
        samp();
        r1seen |= bus.resp1_valid;
        nchk++;
        if ({bus.resp0_valid, bus.busy} !== 2'b00) begin
            nfail++; $display("FAIL single_done: resp0_valid,busy=%b want 00", {bus.resp0_valid, bus.busy});
        end
        nchk++;
        if (r1seen !== 1'b0) begin
            nfail++; $display("FAIL single_resp1_quiet: resp1_valid seen=%b want 0", r1seen);
        end
    endtask

    task automatic test_operand_hold();
        exp_t e;
        tick();
        set0(8'h93, 8'h11, 1'b0, 4'd2);
        bus.req0_valid = 1'b1;
        samp();
        tick();
        bus.req0_valid = 1'b0;
        bus.req0_a = 8'h00;
        samp();
        nchk++;
        if (bus.alu_a !== 8'h93) begin
            nfail++; $display("FAIL hold_alu_a: got %h want 93", bus.alu_a);
        end
        tick();
        samp();
        nchk++;
        if (bus.resp0_valid !== 1'b1 || exp_q.size() == 0) begin
            nfail++; $display("FAIL hold_resp: resp0_valid=%b sb=%0d want 1/1", bus.resp0_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (bus.resp_y !== e.y || bus.resp_y !== 8'h82) begin
                nfail++; $display("FAIL hold_y: got %h want %h", bus.resp_y, e.y);
            end
        end
        tick();
    endtask

    task automatic test_tie();
        exp_t e;
        int ngot = 0;
        rst = 1'b1;
        set0(8'h10, 8'h20, 1'b0, 4'd7);
        set1(8'hF0, 8'h0F, 1'b0, 4'd2);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
        exp_q.delete(); grant_log.delete(); grant_cyc.delete();
        samp();
        nchk++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            nfail++; $display("FAIL tie_reset_ready: got %b want 00", {bus.req0_ready, bus.req1_ready});
        end
        for (int c = 0; c < 30 && ngot < 4; c++) begin
            tick();
            rst = 1'b0;
            samp();
            if (bus.resp0_valid || bus.resp1_valid) begin
                nchk++;
                if (exp_q.size() == 0) begin
                    nfail++; $display("FAIL tie_unexpected_resp: sb empty");
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.resp1_valid, bus.resp0_valid} !== (e.owner ? 2'b10 : 2'b01) || bus.resp_y !== e.y) begin
                        nfail++;
                        $display("FAIL tie_resp: valid=%b y=%h want owner%0d y=%h",
                                 {bus.resp1_valid, bus.resp0_valid}, bus.resp_y, e.owner, e.y);
                    end
                end
                ngot++;
            end
        end
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        nchk++;
        if (ngot != 4) begin
            nfail++; $display("FAIL tie_timeout: responses %0d want 4", ngot);
        end
        nchk++;
        if (grant_log.size() != 4 || grant_log[0] != 0 || grant_log[1] != 1 ||
            grant_log[2] != 0 || grant_log[3] != 1) begin
            nfail++; $display("FAIL tie_order: %0d grants, got %p want 0,1,0,1", grant_log.size(), grant_log);
        end
        nchk++;
        if (grant_cyc.size() != 4 || grant_cyc[1] - grant_cyc[0] != 3 ||
            grant_cyc[2] - grant_cyc[1] != 3 || grant_cyc[3] - grant_cyc[2] != 3) begin
            nfail++; $display("FAIL back_to_back_spacing: cycles %p want step 3", grant_cyc);
        end
        samp();
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic [7:0] y0;
        logic held_ok = 1'b1;
        tick();
        set1(8'h55, 8'h0F, 1'b1, 4'd7);
        bus.req1_valid = 1'b1; bus.resp1_ready = 1'b0; bus.resp0_ready = 1'b1;
        samp();
        nchk++;
        if (bus.req1_ready !== 1'b1) begin
            nfail++; $display("FAIL bp_accept1: got %b want 1", bus.req1_ready);
        end
        tick();
        bus.req1_valid = 1'b0;
        set0(8'h01, 8'h02, 1'b0, 4'd7);
        bus.req0_valid = 1'b1;
        samp();
        tick();
        samp();
        y0 = bus.resp_y;
        nchk++;
        if (bus.resp1_valid !== 1'b1 || exp_q.size() == 0) begin
            nfail++; $display("FAIL bp_resp1: valid=%b sb=%0d want 1/1", bus.resp1_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (e.owner !== 1'b1 || bus.resp_y !== e.y || bus.resp_y !== 8'h65) begin
                nfail++; $display("FAIL bp_y: got %h want %h", bus.resp_y, e.y);
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) bus.resp1_ready = 1'b1;
            samp();
            if (bus.resp1_valid !== 1'b1 || bus.resp_y !== y0 || bus.req0_ready !== 1'b0)
                held_ok = 1'b0;
        end
        nchk++;
        if (held_ok !== 1'b1) begin
            nfail++; $display("FAIL bp_hold: resp1_valid/resp_y/req0_ready not held (y0=%h)", y0);
        end
        tick();
        bus.resp1_ready = 1'b0;
        samp();
        nchk++;
        if ({bus.req0_ready, bus.resp1_valid} !== 2'b10) begin
            nfail++; $display("FAIL bp_regrant: ready0,resp1_valid=%b want 10", {bus.req0_ready, bus.resp1_valid});
        end
        tick();
        bus.req0_valid = 1'b0;
        samp();
        tick();
        samp();
        nchk++;
        if (bus.resp0_valid !== 1'b1 || exp_q.size() == 0) begin
            nfail++; $display("FAIL bp_resp0: valid=%b sb=%0d want 1/1", bus.resp0_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (bus.resp_y !== e.y) begin
                nfail++; $display("FAIL bp_resp0_y: got %h want %h", bus.resp_y, e.y);
            end
        end
        tick();
    endtask

    task automatic test_reset_midop();
        logic rv_seen = 1'b0;
        tick();
        set0(8'h21, 8'h03, 1'b0, 4'd7);
        bus.req0_valid = 1'b1; bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
        samp();
        tick();
        bus.req0_valid = 1'b0;
        #2;
        nchk++;
        if (bus.busy !== 1'b1) begin
            nfail++; $display("FAIL midop_exec: busy=%b want 1", bus.busy);
        end
        rst = 1'b1;
        #1;
        nchk++;
        if (all_outs() !== 34'd0) begin
            nfail++; $display("FAIL midop_async_reset: got %h want 0", all_outs());
        end
        exp_q.delete();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            samp();
            rv_seen |= bus.resp0_valid | bus.resp1_valid;
            tick();
        end
        nchk++;
        if (rv_seen !== 1'b0) begin
            nfail++; $display("FAIL midop_no_resp: resp_valid seen=%b want 0", rv_seen);
        end
        set1(8'h44, 8'h44, 1'b0, 4'd2);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        samp();
        nchk++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            nfail++; $display("FAIL midop_tie_req0: ready0/1=%b want 10", {bus.req0_ready, bus.req1_ready});
        end
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        samp();
        tick();
        samp();
        nchk++;
        if (bus.resp0_valid !== 1'b1 || exp_q.size() != 1 || bus.resp_y !== exp_q[0].y) begin
            nfail++; $display("FAIL midop_after_resp: valid=%b y=%h sb=%0d", bus.resp0_valid, bus.resp_y, exp_q.size());
        end
        exp_q.delete();
        tick();
    endtask

`ifdef ALU_SHARE_ARB_PERF_EN
    task automatic test_perf();
        int ng = 0;
        rst = 1'b1;
        set0(8'h01, 8'h01, 1'b0, 4'd7);
        set1(8'h02, 8'h02, 1'b0, 4'd7);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
        exp_q.delete();
        samp();
        for (int c = 0; c < 60 && (ng < 5 || exp_q.size() > 0); c++) begin
            tick();
            rst = 1'b0;
            if (ng >= 3) bus.req0_valid = 1'b0;
            if (ng >= 5) bus.req1_valid = 1'b0;
            samp();
            if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) ng++;
            if ((bus.resp0_valid || bus.resp1_valid) && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        nchk++;
        if (g0_cnt !== 16'd2 || g1_cnt !== 16'd3 || cf_cnt !== 16'd3) begin
            nfail++; $display("FAIL perf_counts: g0=%0d g1=%0d cf=%0d want 2/3/3", g0_cnt, g1_cnt, cf_cnt);
        end
        tick();
        bus.req1_valid = 1'b1;
        samp();
        tick();
        bus.req1_valid = 1'b0;
        samp();
        tick();
        samp();
        tick();
        samp();
        exp_q.delete();
        nchk++;
        if (g1_cnt !== 16'd4 || g1_s !== 2'd3 || g0_s !== 2'd2 || cf_s !== 2'd3) begin
            nfail++; $display("FAIL perf_saturate: g1=%0d g1_s=%0d g0_s=%0d cf_s=%0d want 4/3/2/3",
                              g1_cnt, g1_s, g0_s, cf_s);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
        set0('0, '0, 1'b0, '0);
        set1('0, '0, 1'b0, '0);
        test_reset();
        test_single_op();
        test_operand_hold();
        test_tie();
        test_backpressure();
        test_reset_midop();
`ifdef ALU_SHARE_ARB_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
